// File: rtl/turbo_term_ctrl.sv
// Turbo-encoder block sequencer: accepts K input bits, steps the constituent
// encoders once per accepted bit, then loads and shifts out TAIL_LEN
// termination columns. Owns every encoder / termination enable.
module turbo_term_ctrl #(
  parameter int KW       = 13,
  parameter int K_MIN    = 40,
  parameter int K_MAX    = 6144,
  parameter int TAIL_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] blk_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          enc_en,
  output logic          term_load,
  output logic          term_shift,
  output logic          tail_valid,
  output logic          busy,
  output logic          done,
  output logic          len_err,
  output logic [KW-1:0] bit_cnt,
  output logic [2:0]    fsm_state
);

  localparam int TCW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(TAIL_LEN - 1);
  localparam logic [KW-1:0]  K_MIN_W   = KW'(K_MIN);
  localparam logic [KW-1:0]  K_MAX_W   = KW'(K_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_TLOAD = 3'd2,
    S_TAIL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [KW-1:0]  k_reg;
  logic [TCW-1:0] tail_cnt;
  logic           len_ok;
  logic           last_bit;
  logic           last_tail;

  // Handshakes: a transfer happens on a rising edge where the producer's
  // valid and the consumer's ready are both high. Input bits transfer on
  // in_valid & in_ready (= enc_en); tail columns transfer on
  // tail_valid & out_ready (= term_shift). Neither side may make its
  // valid/ready depend on the other's in a way that forms a loop; here
  // in_ready follows out_ready so input stalls whenever the encoded output
  // stream is stalled.

  assign fsm_state = state;
  assign len_ok    = (blk_len >= K_MIN_W) && (blk_len <= K_MAX_W);
  assign last_bit  = ((bit_cnt + KW'(1)) == k_reg);
  assign last_tail = (tail_cnt == TAIL_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort has priority over everything, including start
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && len_ok) state_nxt = S_DATA;
        S_DATA:  if (enc_en && last_bit) state_nxt = S_TLOAD;
        S_TLOAD: state_nxt = S_TAIL;
        S_TAIL:  if (term_shift && last_tail) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from registered state plus the live handshake inputs
  always_comb begin
    in_ready   = (state == S_DATA) && out_ready;
    enc_en     = in_ready && in_valid;
    term_load  = (state == S_TLOAD);
    term_shift = (state == S_TAIL) && out_ready;
    tail_valid = (state == S_TAIL);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  // Block length latch, bit/tail counters and the length-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_reg    <= '0;
      bit_cnt  <= '0;
      tail_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= (state == S_IDLE) && start && !abort && !len_ok;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start && len_ok) begin
              k_reg   <= blk_len;
              bit_cnt <= '0;
            end
          end
          S_DATA:  if (enc_en) bit_cnt <= bit_cnt + KW'(1);
          S_TLOAD: tail_cnt <= '0;
          S_TAIL:  if (term_shift) tail_cnt <= tail_cnt + TCW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/turbo_term_ctrl.md
# turbo_term_ctrl

Sequencer for one turbo-encoder code block: accepts K input bits, steps both constituent encoders once per accepted bit, then drives trellis termination. It captures the encoder registers into the termination shift registers and shifts out 4 tail columns (d0/d1/d2 per column) under output backpressure. It sits between the block-level input interface and the constituent encoders / trellis termination datapath, and owns all of their enables.

## Interface
- `KW`, 13: width of block-length and bit counter (K up to 6144).
- `K_MIN`, 40: smallest legal block length.
- `K_MAX`, 6144: largest legal block length.
- `TAIL_LEN`, 4: tail columns shifted out per block (depth of the termination shift registers).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a block; sampled only in IDLE.
- `blk_len`  in  KW  block length K, sampled with `start`.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `in_valid`  in  1  input bit present.
- `in_ready`  out  1  controller accepts input bit this cycle.
- `out_ready`  in  1  downstream accepts encoded/tail output this cycle.
- `enc_en`  out  1  step constituent encoders (one input bit consumed).
- `term_load`  out  1  one-cycle pulse: load encoder state into termination shift registers.
- `term_shift`  out  1  shift termination registers one position (tail column consumed).
- `tail_valid`  out  1  d0/d1/d2 currently hold a valid tail column.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on normal block completion.
- `len_err`  out  1  one-cycle pulse: `start` with illegal `blk_len`.
- `bit_cnt`  out  KW  input bits accepted in the current block.

## Operation
- States: IDLE, DATA, TLOAD, TAIL, DONE. Registered state, counters and pulse outputs; `in_ready`, `enc_en`, `term_shift` are combinational from state and handshakes.
- IDLE: `start`=1 with K_MIN <= `blk_len` <= K_MAX -> latch K, clear `bit_cnt`, go DATA. Illegal length -> `len_err`=1 next cycle, stay IDLE. `start` outside IDLE is ignored.
- DATA: `in_ready` = `out_ready`; `enc_en` = `in_valid & in_ready`; each handshake increments `bit_cnt`. On the handshake making `bit_cnt` = K, go TLOAD.
- TLOAD: `term_load`=1 for exactly this cycle; `in_ready`=0, `enc_en`=0. Next state TAIL, tail counter cleared.
- TAIL: `tail_valid`=1; `term_shift` = `out_ready`. Each shift increments the tail counter (2 bits). The shift with counter = TAIL_LEN-1 -> DONE. `out_ready`=0 holds the column and the state indefinitely.
- DONE: `done`=1, `busy`=1 for one cycle -> IDLE. `bit_cnt` holds K until the next accepted `start`.
- `abort`=1 in any state -> IDLE next edge. No `done`, no `term_load`; outputs deassert. `abort` beats `start` in the same cycle. `abort` in TLOAD suppresses nothing already issued that cycle, but TAIL is never entered.
- Reset (`rst`=0, any time including mid-block): state IDLE, `bit_cnt`=0, tail counter=0. All outputs 0: `in_ready`, `enc_en`, `term_load`, `term_shift`, `tail_valid`, `busy`, `done`, `len_err`.
- Invariants: `enc_en` only in DATA; `term_load` only in TLOAD; `term_shift` only in TAIL. Exactly K `enc_en` and TAIL_LEN `term_shift` cycles per completed block.

## Timing
- `start` sampled at edge N -> `busy`=1 and `in_ready` may be high in cycle N+1.
- The last data handshake at edge M makes `term_load`=1 in cycle M+1 and `tail_valid`=1 in cycle M+2.
- With `out_ready` held high: tail shifts at cycles M+2..M+5, `done` in cycle M+6, IDLE (`busy`=0) in cycle M+7.
- Unstalled block duration from `start` edge to `done`: K + TAIL_LEN + 2 cycles.
- `len_err`, `done` and `term_load` are single-cycle pulses and never coincide.
- Back-to-back blocks: `start` may be asserted in the first IDLE cycle after DONE.

## Test plan
- K=40, `in_valid`=`out_ready`=1 from `start`: exactly 40 `enc_en` cycles, `term_load` 1 cycle later, 4 `term_shift` cycles, `done` 46 cycles after the `start` edge, `bit_cnt`=40.
- K=40, `out_ready` toggled 1/0 every cycle in DATA and TAIL: 40 `enc_en` and 4 `term_shift`, none while `out_ready`=0, `tail_valid` held through stalls.
- `start` with `blk_len`=39, then with 6145: `len_err` pulses each time, `busy` stays 0; `blk_len`=6144 accepted and completes with `bit_cnt`=6144.
- `abort` after 17 bits of K=100: IDLE next cycle, no `term_load`/`done`. A new `start` (K=40) then completes normally with `bit_cnt` restarting from 0.
- `rst` low in TAIL after 2 shifts: all outputs 0 immediately (async). After release, the block starts cleanly from IDLE.
- `start` held high during DATA and DONE: no restart mid-block. The next block begins on the IDLE cycle after `done`; `start` and `abort` together in IDLE -> stays IDLE.
